// File: rtl/seq_det_pkg.sv
// Shared types and elaboration helpers for the serial pattern detector.
// The detection state is derived from how many history bits are valid.
package seq_det_pkg;

    typedef enum logic [1:0] {
        DET_EMPTY   = 2'd0,
        DET_FILLING = 2'd1,
        DET_ARMED   = 2'd2
    } det_state_e;

    // Width of the fill counter: holds 0..pat_len-1.
    function automatic int fill_width(input int pat_len);
        return (pat_len < 2) ? 1 : $clog2(pat_len);
    endfunction

    function automatic bit pattern_width_ok(input int pattern_bits, input int pat_len);
        return (pat_len >= 2) && (pattern_bits == pat_len);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial detector for a compile-time bit pattern (MSB received first), with
// selectable overlap, a registered match pulse and a saturating hit counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter     PATTERN = 4'b1011,
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int                 HIST_W   = PAT_LEN - 1;
    localparam int                 FILL_W   = fill_width(PAT_LEN);
    localparam logic [FILL_W-1:0]  ARM_FILL = FILL_W'(PAT_LEN - 1);
    localparam logic [PAT_LEN-1:0] PAT      = PAT_LEN'(PATTERN);

    if (!pattern_width_ok($bits(PATTERN), PAT_LEN)) begin : g_bad_pattern
        $error("seq_pattern_detector: PATTERN width must equal PAT_LEN (>= 2)");
    end

    logic [HIST_W-1:0] hist, hist_d;
    logic [FILL_W-1:0] fill, fill_d;
    logic              out_d;
    logic              match_now;
    det_state_e        state;

    always_comb begin
        if (fill == ARM_FILL)   state = DET_ARMED;
        else if (fill == '0)    state = DET_EMPTY;
        else                    state = DET_FILLING;
    end

    assign match_now = in_valid && (state == DET_ARMED) && ({hist, in} == PAT);

    always_comb begin
        hist_d = hist;
        fill_d = fill;
        out_d  = 1'b0;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = HIST_W'({hist, in});
            out_d  = match_now;
            case (state)
                DET_EMPTY, DET_FILLING: fill_d = fill + FILL_W'(1);
                // Non-overlapping mode discards the history that formed the hit.
                DET_ARMED:              fill_d = (match_now && !OVERLAP) ? '0 : fill;
                default:                fill_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
            out  <= 1'b0;
        end else begin
            hist <= hist_d;
            fill <= fill_d;
            out  <= out_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (match_now),
        .count (match_count),
        .sat   (count_sat)
    );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: three configurations share one stimulus
// stream; a bit-history model predicts out/count/sat for each.
module tb_seq_pattern_detector;

    logic clk = 1'b0;
    logic reset, clear, in_valid, in;
    logic       out0, out1, out2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic       sat0, sat1, sat2;

    always #5 clk = ~clk;

    // dut0: defaults (overlap); dut1: non-overlap; dut2: non-overlap, 2-bit counter
    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in),
        .out(out0), .match_count(cnt0), .count_sat(sat0));
    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in),
        .out(out1), .match_count(cnt1), .count_sat(sat1));
    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in),
        .out(out2), .match_count(cnt2), .count_sat(sat2));

    int checks   = 0;
    int failures = 0;
    string phase = "reset";

    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    logic [9:0] exp_q2[$];

    // Model: bits seen since last restart and their last four values
    int m_len[3];
    int m_val[3];
    int m_cnt[3];
    bit m_out[3];

    function automatic bit ovl(input int i);
        return (i == 0);
    endfunction

    function automatic int maxc(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_len[i] = 0; m_val[i] = 0; m_cnt[i] = 0; m_out[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic v, input logic b, input logic c);
        bit hit;
        logic [9:0] e;
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                m_len[i] = 0; m_val[i] = 0; m_cnt[i] = 0; m_out[i] = 1'b0;
            end else if (v) begin
                m_val[i] = ((m_val[i] << 1) | int'(b)) & 'hF;
                m_len[i]++;
                hit = (m_len[i] >= 4) && (m_val[i] == 'b1011);
                m_out[i] = hit;
                if (hit) begin
                    if (m_cnt[i] < maxc(i)) m_cnt[i]++;
                    if (!ovl(i)) m_len[i] = 0;
                end
            end else begin
                m_out[i] = 1'b0;
            end
            e = {m_out[i], (m_cnt[i] == maxc(i)), 8'(m_cnt[i])};
            case (i)
                0:       exp_q0.push_back(e);
                1:       exp_q1.push_back(e);
                default: exp_q2.push_back(e);
            endcase
        end
    endtask

    task automatic compare_outputs();
        if (exp_q0.size() == 0) check("dut0_q_empty", 1, 0);
        else check("dut0_out_sat_cnt", {out0, sat0, cnt0}, exp_q0.pop_front());
        if (exp_q1.size() == 0) check("dut1_q_empty", 1, 0);
        else check("dut1_out_sat_cnt", {out1, sat1, cnt1}, exp_q1.pop_front());
        if (exp_q2.size() == 0) check("dut2_q_empty", 1, 0);
        else check("dut2_out_sat_cnt", {out2, sat2, 6'b0, cnt2}, exp_q2.pop_front());
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        @(negedge clk);
        in_valid = v; in = b; clear = c;
        model_step(v, b, c);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic stream(input logic [31:0] bits, input int n, input bit gaps);
        for (int k = n - 1; k >= 0; k--) begin
            step(1'b1, bits[k], 1'b0);
            if (gaps) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out0"}, {out0, sat0, cnt0}, 0);
        check({tag, "_out1"}, {out1, sat1, cnt1}, 0);
        check({tag, "_out2"}, {out2, sat2, cnt2}, 0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        @(negedge clk);
        reset = 1'b0;

        phase = "basic";
        stream(32'b1011, 4, 1'b0);
        check("pulse_after_4th", {out0, out1, out2}, 3'b111);
        step(1'b1, 1'b0, 1'b0);
        check("count_one", cnt0, 1);

        phase = "overlap";
        step(1'b0, 1'b0, 1'b1);
        stream(32'b1011011, 7, 1'b0);
        check("ovl_count", cnt0, 2);
        check("novl_count", cnt1, 1);

        phase = "gaps";
        step(1'b0, 1'b0, 1'b1);
        stream(32'b1011, 4, 1'b1);
        check("gap_count", cnt0, 1);

        phase = "clear_prio";
        step(1'b0, 1'b0, 1'b1);
        stream(32'b101, 3, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("clear_no_pulse", {out0, cnt0}, 0);
        step(1'b1, 1'b1, 1'b0);
        check("single_bit_no_match", out0, 0);
        stream(32'b011, 3, 1'b0);
        check("refill_match", out0, 1);

        phase = "saturate";
        step(1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 5; r++) stream(32'b1011, 4, 1'b0);
        check("sat_count", cnt2, 3);
        check("sat_flag", sat2, 1);
        check("wide_count", cnt1, 5);

        phase = "async_reset";
        stream(32'b1011, 4, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        check("post_reset_no_pulse", out0, 0);
        stream(32'b011, 3, 1'b0);

        phase = "random";
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 40) == 0));
        end

        phase = "drain";
        check("queues_drained", exp_q0.size() + exp_q1.size() + exp_q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
